// File: rtl/bank_scheduler.sv
// bank_scheduler: single-bank DRAM command sequencer with an open-page policy,
// down-counter timing (tRCD/tRP/tRAS/tRFC/burst) and periodic refresh.
// A state's command is registered on the edge that leaves that state, so
// commands appear one cycle after the state that produces them.
module bank_scheduler #(
   parameter int ROWS  = 131072,
   parameter int COLS  = 1024,
   parameter int BL    = 8,
   parameter int TRCD  = 4,
   parameter int TRP   = 4,
   parameter int TRAS  = 10,
   parameter int TRFC  = 16,
   parameter int TREFI = 1024
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     halt,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic                     req_write,
   input  logic [$clog2(ROWS)-1:0]  req_row,
   input  logic [$clog2(COLS)-1:0]  req_col,
   output logic [18:0]              commands,
   output logic [$clog2(ROWS)-1:0]  row,
   output logic [$clog2(COLS)-1:0]  column,
   output logic                     rd_window,
   output logic                     wr_window,
   output logic                     row_open
);

   localparam int RW    = $clog2(ROWS);
   localparam int CW    = $clog2(COLS);
   localparam int M1    = (TRAS > TRFC) ? TRAS : TRFC;
   localparam int M2    = (M1 > BL) ? M1 : BL;
   localparam int M3    = (M2 > TREFI) ? M2 : TREFI;
   localparam int CNT_W = $clog2(M3 + 1);

   // Wait-state loads: a wait state loaded with k lasts k+1 cycles, and the
   // following issue state adds one more cycle before its command appears.
   // TRCD and TRP must therefore be at least 2.
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] TRCD_LD  = CNT_W'(TRCD - 2);
   localparam logic [CNT_W-1:0] TRP_LD   = CNT_W'(TRP - 2);
   localparam logic [CNT_W-1:0] TRAS_LD  = CNT_W'(TRAS - 1);
   localparam logic [CNT_W-1:0] TRFC_LD  = CNT_W'(TRFC - 1);
   localparam logic [CNT_W-1:0] BL_LD    = CNT_W'(BL - 1);
   localparam logic [CNT_W-1:0] TREFI_M1 = CNT_W'(TREFI - 1);

   localparam logic [18:0] CMD_ACT = 19'h40000;
   localparam logic [18:0] CMD_PR  = 19'h00080;
   localparam logic [18:0] CMD_RD  = 19'h00020;
   localparam logic [18:0] CMD_REF = 19'h00008;
   localparam logic [18:0] CMD_WR  = 19'h00002;

   typedef enum logic [3:0] {
      S_IDLE, S_PRE, S_WAIT_RP, S_ACT, S_WAIT_RCD, S_CAS, S_BURST, S_REF, S_WAIT_RFC
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] tras_q, tras_d;
   logic [CNT_W-1:0] timer_q, timer_d;
   logic             ref_pend_q, ref_pend_d;
   logic             ref_path_q, ref_path_d;
   logic             lat_write_q, lat_write_d;
   logic [RW-1:0]    lat_row_q, lat_row_d;
   logic [CW-1:0]    lat_col_q, lat_col_d;
   logic [18:0]      cmd_q, cmd_d;
   logic [RW-1:0]    row_q, row_d;
   logic [CW-1:0]    col_q, col_d;
   logic             rdy_q, rdy_d;
   logic             rd_win_q, rd_win_d;
   logic             wr_win_q, wr_win_d;
   logic             open_q, open_d;
   logic             wrap;

   // Next-state, timing counters and registered command outputs.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      tras_d      = tras_q;
      timer_d     = timer_q;
      ref_pend_d  = ref_pend_q;
      ref_path_d  = ref_path_q;
      lat_write_d = lat_write_q;
      lat_row_d   = lat_row_q;
      lat_col_d   = lat_col_q;
      cmd_d       = '0;
      row_d       = row_q;
      col_d       = col_q;
      rdy_d       = rdy_q;
      rd_win_d    = rd_win_q;
      wr_win_d    = wr_win_q;
      open_d      = open_q;
      wrap        = (timer_q == TREFI_M1);
      if (!halt) begin
         timer_d    = wrap ? '0 : timer_q + CNT_ONE;
         ref_pend_d = ref_pend_q | wrap;
         if (tras_q != '0) tras_d = tras_q - CNT_ONE;
         case (state_q)
            S_IDLE: begin
               if (rdy_q && req_valid) begin
                  lat_write_d = req_write;
                  lat_row_d   = req_row;
                  lat_col_d   = req_col;
                  rdy_d       = 1'b0;
                  if (open_q && (row_q == req_row)) state_d = S_CAS;
                  else if (open_q)                  state_d = S_PRE;
                  else                              state_d = S_ACT;
               end else if (ref_pend_q) begin
                  rdy_d      = 1'b0;
                  ref_path_d = 1'b1;
                  state_d    = open_q ? S_PRE : S_REF;
               end else begin
                  // Drop ready on the same edge a refresh becomes pending.
                  rdy_d = ~ref_pend_d;
               end
            end
            S_PRE: begin
               if (tras_q == '0) begin
                  cmd_d   = CMD_PR;
                  open_d  = 1'b0;
                  cnt_d   = TRP_LD;
                  state_d = S_WAIT_RP;
               end
            end
            S_WAIT_RP: begin
               if (cnt_q == '0) state_d = ref_path_q ? S_REF : S_ACT;
               else             cnt_d   = cnt_q - CNT_ONE;
            end
            S_ACT: begin
               cmd_d   = CMD_ACT;
               row_d   = lat_row_q;
               open_d  = 1'b1;
               tras_d  = TRAS_LD;
               cnt_d   = TRCD_LD;
               state_d = S_WAIT_RCD;
            end
            S_WAIT_RCD: begin
               if (cnt_q == '0) state_d = S_CAS;
               else             cnt_d   = cnt_q - CNT_ONE;
            end
            S_CAS: begin
               cmd_d    = lat_write_q ? CMD_WR : CMD_RD;
               col_d    = lat_col_q;
               rd_win_d = ~lat_write_q;
               wr_win_d = lat_write_q;
               cnt_d    = BL_LD;
               state_d  = S_BURST;
            end
            S_BURST: begin
               if (cnt_q == '0) begin
                  rd_win_d = 1'b0;
                  wr_win_d = 1'b0;
                  rdy_d    = ~ref_pend_d;
                  state_d  = S_IDLE;
               end else begin
                  cnt_d = cnt_q - CNT_ONE;
               end
            end
            S_REF: begin
               cmd_d   = CMD_REF;
               cnt_d   = TRFC_LD;
               state_d = S_WAIT_RFC;
            end
            S_WAIT_RFC: begin
               if (cnt_q == '0) begin
                  open_d     = 1'b0;
                  ref_path_d = 1'b0;
                  ref_pend_d = wrap;
                  rdy_d      = ~wrap;
                  state_d    = S_IDLE;
               end else begin
                  cnt_d = cnt_q - CNT_ONE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // State and output registers with asynchronous clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         tras_q      <= '0;
         timer_q     <= '0;
         ref_pend_q  <= 1'b0;
         ref_path_q  <= 1'b0;
         lat_write_q <= 1'b0;
         lat_row_q   <= '0;
         lat_col_q   <= '0;
         cmd_q       <= '0;
         row_q       <= '0;
         col_q       <= '0;
         rdy_q       <= 1'b0;
         rd_win_q    <= 1'b0;
         wr_win_q    <= 1'b0;
         open_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         tras_q      <= tras_d;
         timer_q     <= timer_d;
         ref_pend_q  <= ref_pend_d;
         ref_path_q  <= ref_path_d;
         lat_write_q <= lat_write_d;
         lat_row_q   <= lat_row_d;
         lat_col_q   <= lat_col_d;
         cmd_q       <= cmd_d;
         row_q       <= row_d;
         col_q       <= col_d;
         rdy_q       <= rdy_d;
         rd_win_q    <= rd_win_d;
         wr_win_q    <= wr_win_d;
         open_q      <= open_d;
      end
   end

   // Ready is masked by halt so no handshake can complete on a frozen edge.
   assign req_ready = rdy_q & ~halt;
   assign commands  = cmd_q;
   assign row       = row_q;
   assign column    = col_q;
   assign rd_window = rd_win_q;
   assign wr_window = wr_win_q;
   assign row_open  = open_q;

endmodule

// File: doc/bank_scheduler.md
Name: bank_scheduler

Overview:
Per-bank command sequencer in front of one DRAM bank model. It accepts single read/write requests (row, column) from a host-side port and emits one-hot 19-bit command vectors (ACT/PR/RD/WR/REF) with row/column addresses. It applies an open-page policy, enforces tRCD/tRP/tRAS/tRFC/burst spacing with down-counters, and inserts periodic refresh. It drives the bank's commands, row and column inputs directly.

Parameters:
ROWS, 131072, rows per bank; row width = $clog2(ROWS)
COLS, 1024, columns per row; column width = $clog2(COLS)
BL, 8, burst length in cycles (bank occupancy after RD/WR)
TRCD, 4, min cycles ACT -> RD/WR
TRP, 4, min cycles PR -> ACT/REF
TRAS, 10, min cycles ACT -> PR
TRFC, 16, cycles REF -> next command
TREFI, 1024, refresh interval in cycles

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
halt  input  1  freeze: state, counters and refresh timer hold; commands forced 0
req_valid  input  1  request present
req_ready  output  1  request accepted on clk edge when req_valid && req_ready
req_write  input  1  1 = write, 0 = read
req_row  input  $clog2(ROWS)  target row
req_col  input  $clog2(COLS)  start column
commands  output  19  one-hot command: bit18 ACT, bit7 PR, bit5 RD, bit3 REF, bit1 WR; all other bits always 0
row  output  $clog2(ROWS)  row address, valid with ACT
column  output  $clog2(COLS)  column address, valid with RD/WR
rd_window  output  1  high for BL cycles starting the cycle RD is on commands
wr_window  output  1  high for BL cycles starting the cycle WR is on commands
row_open  output  1  a row is active in the bank

Behaviour:
- Reset (async, reset_n=0): state IDLE, commands=0, row=0, column=0, req_ready=0, rd_window=0, wr_window=0, row_open=0, all counters 0, refresh timer 0, ref_pending=0.
- All outputs registered. Every command is exactly one cycle wide; at most one bit of commands is set in any cycle.
- States: IDLE, PRE, WAIT_RP, ACT, WAIT_RCD, CAS, BURST, REF, WAIT_RFC.
- req_ready=1 only in IDLE, with halt=0 and ref_pending=0. Accepted request fields are latched.
- Acceptance at edge N:
  - Hit (row_open and latched row == req_row): CAS command on commands in cycle N+1.
  - Closed: ACT in N+1, CAS TRCD cycles after ACT.
  - Miss: PR issued once TRAS has elapsed since the last ACT (earliest N+1), ACT TRP cycles after PR, CAS TRCD cycles after ACT.
- CAS: RD or WR with column=latched col; rd_window or wr_window set for BL cycles. BURST lasts BL cycles including the CAS cycle, then IDLE with req_ready=1 the next cycle. Row stays open.
- Refresh timer: increments every non-halted cycle. When it reaches TREFI-1 it wraps to 0 and sets ref_pending; it keeps counting during refresh.
  - ref_pending is serviced only from IDLE; an in-flight request always completes first.
  - If row_open: PR (TRAS respected), wait TRP, then REF. Otherwise REF immediately.
  - After REF: WAIT_RFC for TRFC cycles; row_open=0, ref_pending cleared, then IDLE.
  - Pending refresh has priority over req_valid.
- ACT sets row_open=1; PR clears it.
- halt=1: no transition, no counter change, commands=0, rd/wr_window hold. A command due during halt issues on the first non-halted cycle. Spacing is measured in non-halted cycles.
- Counters are $clog2(max(TRAS,TRFC,BL,TREFI)+1) bits wide; there is no overflow.
- Reset mid-operation abandons the request; no command is emitted afterwards until a new acceptance.

Test Plan:
- Reset, then read row 5 col 16, TRCD=4: ACT(row=5) in cycle 1 after accept, RD(col=16) cycle 5, rd_window high cycles 5-12, req_ready high cycle 13.
- Write to row 5 col 32 after the previous read: WR in cycle 1 after accept, no ACT/PR, wr_window high 8 cycles.
- Read row 9 with row 5 open, accepted 2 cycles after ACT: PR delayed until TRAS=10 after ACT, ACT(row=9) TRP=4 later, RD TRCD=4 after that.
- TREFI=64 with row open and idle: PR, REF 4 cycles later, req_ready low for TRFC=16 cycles, row_open=0; a request held during refresh is accepted in the first IDLE cycle and issues ACT.
- halt pulsed for 3 cycles between ACT and RD: commands=0 during halt, RD delayed by exactly 3 cycles.
- reset_n dropped mid-burst: all outputs 0 immediately (asynchronously); the next request after release issues ACT (row closed).
